// File: rtl/prog_seq_detect.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq_detect
// Purpose  : Mealy serial-pattern detector with a runtime-loadable N-bit
//            pattern, per-bit care mask, overlap/non-overlap mode,
//            input-valid gating and a saturating match counter.
// Revision : 1.0  initial release
// ============================================================================
module prog_seq_detect #(
  parameter int unsigned      N           = 3,
  parameter logic [N-1:0]     DEFAULT_PAT = 3'b101,
  parameter int unsigned      CW          = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_in,
  input  logic [N-1:0]  mask_in,
  input  logic          overlap,
  input  logic          cnt_clr,
  output logic          match,
  output logic          match_q,
  output logic [CW-1:0] count,
  output logic          cnt_sat
);

  // fill only needs to reach N-1, so clog2(N) bits is enough for N >= 3
  localparam int unsigned    FW       = $clog2(N);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  logic [N-1:0]  pat_q,   pat_d;
  logic [N-1:0]  mask_q,  mask_d;
  logic [N-2:0]  hist_q,  hist_d;
  logic [FW-1:0] fill_q,  fill_d;
  logic [CW-1:0] count_q, count_d;
  logic          match_d;

  logic [N-1:0]  w_window;
  logic          w_hit;

  // Window is the stored history with the current bit as its newest entry
  always_comb begin
    w_window = {hist_q, in};
    w_hit    = (((w_window ^ pat_q) & mask_q) == '0);
    match    = reset & en & ~pat_load & (fill_q == FILL_MAX) & w_hit;
  end

  // Next-state for pattern, mask, history and fill level
  always_comb begin
    pat_d  = pat_q;
    mask_d = mask_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      // A load restarts the search; the bit on `in` is not consumed
      pat_d  = pat_in;
      mask_d = mask_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = {hist_q[N-3:0], in};
      if (match && !overlap) begin
        // Non-overlap: matched bits may not seed the next occurrence
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // Saturating match counter; clear wins but still counts a coincident match
  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = match ? CW'(1) : '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
    match_d = match;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q   <= DEFAULT_PAT;
      mask_q  <= '1;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  // Registered count and its saturation flag are exported directly
  always_comb begin
    count   = count_q;
    cnt_sat = (count_q == CNT_MAX);
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_seq_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_seq_detect
// Purpose  : Self-checking bench for prog_seq_detect (N=3) with two counter
//            widths (CW=8 and CW=2) sharing one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_seq_detect;

  localparam int unsigned  N   = 3;
  localparam logic [N-1:0] DEF = 3'b101;

  logic         clk = 1'b0;
  logic         reset, en, in, pat_load, overlap, cnt_clr;
  logic [N-1:0] pat_in, mask_in;

  logic         match8, mq8, sat8;
  logic         match2, mq2, sat2;
  logic [7:0]   count8;
  logic [1:0]   count2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  prog_seq_detect #(.N(N), .DEFAULT_PAT(DEF), .CW(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match8), .match_q(mq8), .count(count8), .cnt_sat(sat8)
  );

  prog_seq_detect #(.N(N), .DEFAULT_PAT(DEF), .CW(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match2), .match_q(mq2), .count(count2), .cnt_sat(sat2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Bits accepted since the last restart (reset, load, non-overlap match),
  // newest at the back, trimmed to the last N-1.
  logic         hq[$];
  logic [N-1:0] m_pat, m_mask;
  int           m_cnt8, m_cnt2;
  logic         m_mq;
  bit           m_valid = 0;

  function automatic logic model_match();
    logic w;
    if (!reset || !en || pat_load || hq.size() < N - 1) return 1'b0;
    for (int i = 0; i < N; i++) begin
      w = (i == 0) ? in : hq[hq.size() - i];
      if (m_mask[i] && (w != m_pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bump(input int c, input logic m, input int maxv);
    if (cnt_clr) return m ? 1 : 0;
    if (m && c < maxv) return c + 1;
    return c;
  endfunction

  always @(posedge clk) begin
    logic m;
    m = model_match();
    if (!reset) begin
      hq.delete();
      m_pat = DEF; m_mask = '1;
      m_cnt8 = 0; m_cnt2 = 0; m_mq = 1'b0;
      m_valid = 1;
    end else begin
      m_mq = m;
      if (pat_load) begin
        m_pat = pat_in; m_mask = mask_in; hq.delete();
      end else if (en) begin
        if (m && !overlap) hq.delete();
        else begin
          hq.push_back(in);
          if (hq.size() > N - 1) void'(hq.pop_front());
        end
      end
      m_cnt8 = bump(m_cnt8, m, 255);
      m_cnt2 = bump(m_cnt2, m, 3);
    end
  end

  // Compare every cycle on the falling edge once the model is initialised
  always @(negedge clk) begin
    logic m;
    if (m_valid) begin
      m = model_match();
      chk("match8", match8, m);
      chk("match2", match2, m);
      chk("match_q8", mq8, m_mq);
      chk("match_q2", mq2, m_mq);
      chk("count8", count8, m_cnt8);
      chk("count2", count2, m_cnt2);
      chk("cnt_sat8", sat8, m_cnt8 == 255);
      chk("cnt_sat2", sat2, m_cnt2 == 3);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic b, input logic exp_m);
    en = 1'b1; in = b; #1;
    chk("match_lit", match8, exp_m);
    tick();
    chk("match_q_lit", mq8, exp_m);
    cnt_clr = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] p, input logic [N-1:0] m);
    pat_load = 1'b1; pat_in = p; mask_in = m; en = 1'b1; in = 1'b1; cnt_clr = 1'b1; #1;
    chk("load_match", match8, 1'b0);
    tick();
    pat_load = 1'b0; cnt_clr = 1'b0; en = 1'b0;
    chk("load_count", count8, 8'd0);
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; in = 1'b1; pat_load = 1'b0; overlap = 1'b1;
    cnt_clr = 1'b0; pat_in = '0; mask_in = '0;
    tick();
    chk("rst_match", match8, 1'b0);
    tick();
    reset = 1'b1; en = 1'b0; #1;
    chk("rst_count", count8, 8'd0);
    chk("rst_mq", mq8, 1'b0);
    chk("rst_sat", sat8, 1'b0);
    tick();

    // Overlap: 1,0,1,0,1 -> matches on bits 3 and 5
    overlap = 1'b1;
    send(1, 0); send(0, 0); send(1, 1); send(0, 0); send(1, 1);
    chk("ovl_count", count8, 8'd2);

    // Non-overlap from a clean state
    load(DEF, 3'b111);
    overlap = 1'b0;
    send(1, 0); send(0, 0); send(1, 1); send(0, 0); send(1, 0);
    chk("novl_count1", count8, 8'd1);
    send(0, 0); send(1, 1);
    chk("novl_count2", count8, 8'd2);

    // Load with don't-care on the middle bit
    load(3'b110, 3'b101);
    overlap = 1'b1;
    send(1, 0); send(0, 0); send(0, 1); send(1, 0); send(1, 0); send(0, 1);
    chk("dc_count", count8, 8'd2);

    // en gating preserves the partial sequence
    load(DEF, 3'b111);
    send(1, 0); send(0, 0);
    en = 1'b0; in = 1'b1; #1;
    chk("gap_match", match8, 1'b0);
    tick(); tick();
    send(1, 1);
    chk("gap_count", count8, 8'd1);

    // Saturation (CW=2) and clear coinciding with a match
    load(DEF, 3'b111);
    overlap = 1'b1;
    send(1, 0); send(0, 0); send(1, 1); send(0, 0); send(1, 1);
    send(0, 0); send(1, 1); send(0, 0); send(1, 1);
    chk("sat_count2", count2, 2'd3);
    chk("sat_flag2", sat2, 1'b1);
    chk("sat_count8", count8, 8'd4);
    send(0, 0);
    cnt_clr = 1'b1;
    send(1, 1);
    chk("clr_count2", count2, 2'd1);
    chk("clr_flag2", sat2, 1'b0);
    chk("clr_count8", count8, 8'd1);

    // All-zero mask: every third bit in non-overlap, every bit in overlap
    load(3'b000, 3'b000);
    overlap = 1'b0;
    send(1, 0); send(1, 0); send(1, 1); send(1, 0); send(1, 0); send(1, 1);
    overlap = 1'b1;
    send(0, 0); send(0, 0); send(0, 1); send(0, 1);
    chk("mask0_count", count8, 8'd4);

    // Reset mid-sequence restores the default pattern
    load(3'b111, 3'b111);
    send(1, 0); send(0, 0);
    reset = 1'b0; en = 1'b1; in = 1'b1; #1;
    chk("midrst_match", match8, 1'b0);
    tick();
    reset = 1'b1;
    chk("midrst_mq", mq8, 1'b0);
    chk("midrst_count", count8, 8'd0);
    send(1, 0); send(0, 0); send(1, 1);
    chk("midrst_count2", count8, 8'd1);

    en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
